// File: rtl/strobe_dec_pkg.sv
// Shared definitions for the strobe decoder: FSM state encoding, guard
// length and the pulse-counter width helper.
package strobe_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Clocks spent in GUARD after a normal completion (guard builds only).
  localparam int GUARD_LEN = 2;

  // The counter must hold PULSE_LEN-1 and GUARD_LEN-1; the +1 keeps the
  // width at least one bit when PULSE_LEN is 1.
  function automatic int cnt_width(input int pulse_len);
    return $clog2(pulse_len + 1);
  endfunction

endpackage

// File: rtl/strobe_dec_chan.sv
// One strobe decoder channel: request/busy/done FSM, pulse counter and a
// registered SEL_W-to-2^SEL_W one-hot-low decode.
// Optional macro STROBE_DEC_GUARD_EN adds a 2-clock GUARD state after a
// normal completion (busy held, all strobes high).
module strobe_dec_chan
  import strobe_dec_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int PULSE_LEN = 1,
  parameter int CNT_W     = cnt_width(PULSE_LEN)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     g_n,
  output logic [(1 << SEL_W)-1:0]  y_n,
  output logic                     busy,
  output logic                     done
);

  localparam int OUTS = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
`ifdef STROBE_DEC_GUARD_EN
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_LEN - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel_q;
  logic             accept;

  // Exactly one bit low: the line addressed by the select.
  function automatic logic [OUTS-1:0] decode_low(input logic [SEL_W-1:0] s);
    return ~(OUTS'(1) << s);
  endfunction

  assign accept = (state == ST_IDLE) && req && !g_n;

  // Select capture: data path only, so no reset; frozen for the whole pulse.
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_q <= sel;
    end
  end

  // Channel FSM with registered strobes, busy and done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      y_n   <= '1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_PULSE;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
            y_n   <= decode_low(sel);
          end
        end
        ST_PULSE: begin
          if (g_n) begin
            // Enable lost: drop the strobe without signalling done.
            state <= ST_IDLE;
            cnt   <= '0;
            y_n   <= '1;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            y_n <= decode_low(sel_q);
          end else begin
            y_n  <= '1;
            done <= 1'b1;
`ifdef STROBE_DEC_GUARD_EN
            state <= ST_GUARD;
            cnt   <= GUARD_LOAD;
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
          end
        end
        ST_GUARD: begin
          // Quiet gap after completion; requests are not looked at here.
          y_n <= '1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          y_n   <= '1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/strobe_decoder.sv
// Multi-channel registered strobe decoder. Each channel turns a select into
// one active-low strobe held for PULSE_LEN clocks, with busy/done handshake
// and abort on loss of the active-low enable.
// Optional macro STROBE_DEC_GUARD_EN adds a post-pulse guard gap per channel.
module strobe_decoder
  import strobe_dec_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int CHANNELS  = 2,
  parameter int PULSE_LEN = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [CHANNELS-1:0]                 req,
  input  logic [CHANNELS*SEL_W-1:0]           sel,
  input  logic [CHANNELS-1:0]                 g_n,
  output logic [CHANNELS*(1 << SEL_W)-1:0]    y_n,
  output logic [CHANNELS-1:0]                 busy,
  output logic [CHANNELS-1:0]                 done
);

  localparam int OUTS  = 1 << SEL_W;
  localparam int CNT_W = cnt_width(PULSE_LEN);

  // Reject out-of-range configurations at elaboration.
  if (SEL_W < 1 || SEL_W > 4) begin : g_bad_sel_w
    $error("strobe_decoder: SEL_W must be 1..4");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("strobe_decoder: CHANNELS must be 1..8");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
    $error("strobe_decoder: PULSE_LEN must be 1..255");
  end

  // Independent channels, outputs concatenated channel 0 in the LSBs.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    strobe_dec_chan #(
      .SEL_W     (SEL_W),
      .PULSE_LEN (PULSE_LEN),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req[c]),
      .sel     (sel[c*SEL_W +: SEL_W]),
      .g_n     (g_n[c]),
      .y_n     (y_n[c*OUTS +: OUTS]),
      .busy    (busy[c]),
      .done    (done[c])
    );
  end

endmodule

// File: tb/tb_strobe_decoder.sv
// Scoreboard bench for strobe_decoder: three instances (PULSE_LEN 3, 5, 2)
// share clock and reset; expected per-cycle outputs are queued when
// stimulus is applied and popped one per clock.
module tb_strobe_decoder;

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] b;
    logic [1:0] d;
  } exp_t;

`ifdef STROBE_DEC_GUARD_EN
  localparam logic GB = 1'b1;
  localparam int   PERIOD = 5;
`else
  localparam logic GB = 1'b0;
  localparam int   PERIOD = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req3 = '0, req5 = '0, req2 = '0;
  logic [3:0] sel3 = '0, sel5 = '0, sel2 = '0;
  logic [1:0] g3 = '1, g5 = '1, g2 = '1;
  logic [7:0] y3, y5, y2;
  logic [1:0] busy3, busy5, busy2, done3, done5, done2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  strobe_decoder #(.SEL_W(2), .CHANNELS(2), .PULSE_LEN(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .sel(sel3), .g_n(g3),
    .y_n(y3), .busy(busy3), .done(done3));
  strobe_decoder #(.SEL_W(2), .CHANNELS(2), .PULSE_LEN(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .req(req5), .sel(sel5), .g_n(g5),
    .y_n(y5), .busy(busy5), .done(done5));
  strobe_decoder #(.SEL_W(2), .CHANNELS(2), .PULSE_LEN(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .sel(sel2), .g_n(g2),
    .y_n(y2), .busy(busy2), .done(done2));

  function automatic exp_t mk(input logic [7:0] y, input logic [1:0] b,
                              input logic [1:0] d);
    exp_t r;
    r.y = y; r.b = b; r.d = d;
    return r;
  endfunction

  function automatic int lows(input logic [3:0] v);
    return $countones(~v);
  endfunction

  // Continuous one-hot-low monitor on every channel of every instance.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (lows(y3[3:0]) > 1 || lows(y3[7:4]) > 1 || lows(y5[3:0]) > 1 ||
          lows(y5[7:4]) > 1 || lows(y2[3:0]) > 1 || lows(y2[7:4]) > 1) begin
        errors++;
        $display("FAIL onehot_low y3=%h y5=%h y2=%h (at most one low bit per channel)",
                 y3, y5, y2);
      end
    end
  end

  task automatic test_reset();
    int i;
    repeat (2) @(negedge clk);
    checks++;
    if ({y3, y5, y2, busy3, busy5, busy2, done3, done5, done2} !== {24'hFFFFFF, 12'h000}) begin
      errors++;
      $display("FAIL reset_idle y=%h/%h/%h busy=%b/%b/%b done=%b/%b/%b exp all-high, zero",
               y3, y5, y2, busy3, busy5, busy2, done3, done5, done2);
    end
    reset_n = 1'b1;
    req3 = 2'b11; sel3 = {2'd1, 2'd2}; g3 = 2'b00;
    @(negedge clk);
    checks++;
    if ({y3, busy3} !== {8'hDB, 2'b11}) begin
      errors++;
      $display("FAIL reset_prepulse y=%h busy=%b exp db 11", y3, busy3);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({y3, busy3, done3} !== {8'hFF, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_async y=%h busy=%b done=%b exp ff 00 00", y3, busy3, done3);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(mk(8'hDB, 2'b11, 2'b00));
    sb.push_back(mk(8'hDB, 2'b11, 2'b00));
    sb.push_back(mk(8'hDB, 2'b11, 2'b00));
    sb.push_back(mk(8'hFF, {GB, GB}, 2'b11));
    sb.push_back(mk(8'hFF, {GB, GB}, 2'b00));
    sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({y3, busy3, done3} !== {e.y, e.b, e.d}) begin
        errors++;
        $display("FAIL reset_release cyc%0d got y=%h b=%b d=%b exp y=%h b=%b d=%b",
                 i, y3, busy3, done3, e.y, e.b, e.d);
      end
      if (i == 0) req3 = 2'b00;
      i++;
    end
  endtask

  task automatic test_basic();
    int i;
    @(negedge clk);
    req3 = 2'b01; sel3 = {2'd0, 2'd2}; g3 = 2'b00;
    repeat (3) sb.push_back(mk(8'hFB, 2'b01, 2'b00));
    sb.push_back(mk(8'hFF, {1'b0, GB}, 2'b01));
    sb.push_back(mk(8'hFF, {1'b0, GB}, 2'b00));
    sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({y3, busy3, done3} !== {e.y, e.b, e.d}) begin
        errors++;
        $display("FAIL basic cyc%0d got y=%h b=%b d=%b exp y=%h b=%b d=%b",
                 i, y3, busy3, done3, e.y, e.b, e.d);
      end
      if (i == 0) req3 = 2'b00;
      i++;
    end
  endtask

  task automatic test_ignore_busy();
    int i;
    @(negedge clk);
    req3 = 2'b01; sel3 = {2'd0, 2'd2}; g3 = 2'b00;
    repeat (3) sb.push_back(mk(8'hFB, 2'b01, 2'b00));
    sb.push_back(mk(8'hFF, {1'b0, GB}, 2'b01));
    sb.push_back(mk(8'hFF, {1'b0, GB}, 2'b00));
    repeat (3) sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({y3, busy3, done3} !== {e.y, e.b, e.d}) begin
        errors++;
        $display("FAIL ignore_busy cyc%0d got y=%h b=%b d=%b exp y=%h b=%b d=%b",
                 i, y3, busy3, done3, e.y, e.b, e.d);
      end
      if (i == 0) begin
        sel3 = {2'd0, 2'd0};
        req3 = 2'b01;
      end
      if (i == 1) req3 = 2'b00;
      i++;
    end
  endtask

  task automatic test_gate_disabled();
    int i;
    @(negedge clk);
    req5 = 2'b01; sel5 = {2'd0, 2'd3}; g5 = 2'b01;
    repeat (3) sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({y5, busy5, done5} !== {e.y, e.b, e.d}) begin
        errors++;
        $display("FAIL gate_disabled cyc%0d got y=%h b=%b d=%b exp y=%h b=%b d=%b",
                 i, y5, busy5, done5, e.y, e.b, e.d);
      end
      if (i == 1) begin
        req5 = 2'b00;
        g5   = 2'b00;
      end
      i++;
    end
  endtask

  task automatic test_abort();
    int i;
    @(negedge clk);
    req5 = 2'b10; sel5 = {2'd1, 2'd0}; g5 = 2'b00;
    repeat (2) sb.push_back(mk(8'hDF, 2'b10, 2'b00));
    repeat (6) sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({y5, busy5, done5} !== {e.y, e.b, e.d}) begin
        errors++;
        $display("FAIL abort cyc%0d got y=%h b=%b d=%b exp y=%h b=%b d=%b",
                 i, y5, busy5, done5, e.y, e.b, e.d);
      end
      if (i == 0) req5 = 2'b00;
      if (i == 1) g5 = 2'b10;
      if (i == 3) g5 = 2'b00;
      i++;
    end
  endtask

  task automatic test_back_to_back();
    int i;
    @(negedge clk);
    req2 = 2'b11; sel2 = {2'd3, 2'd1}; g2 = 2'b00;
    for (int p = 0; p < 3; p++) begin
      sb.push_back(mk(8'h7D, 2'b11, 2'b00));
      sb.push_back(mk(8'h7D, 2'b11, 2'b00));
      sb.push_back(mk(8'hFF, {GB, GB}, 2'b11));
`ifdef STROBE_DEC_GUARD_EN
      sb.push_back(mk(8'hFF, 2'b11, 2'b00));
      sb.push_back(mk(8'hFF, 2'b00, 2'b00));
`endif
    end
    repeat (3) sb.push_back(mk(8'hFF, 2'b00, 2'b00));
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({y2, busy2, done2} !== {e.y, e.b, e.d}) begin
        errors++;
        $display("FAIL back_to_back cyc%0d got y=%h b=%b d=%b exp y=%h b=%b d=%b",
                 i, y2, busy2, done2, e.y, e.b, e.d);
      end
      if (i == 3 * PERIOD - 1) req2 = 2'b00;
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_gate_disabled();
    test_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strobe_decoder.md
Name: strobe_decoder

Overview:
- Parametrised, multi-channel, registered successor to the dual 2-to-4 decoder part.
- Each channel decodes a SEL_W-bit select into one of 2^SEL_W active-low strobe lines.
- Each strobe is a clocked pulse of programmable length, with a request/busy/done handshake and abort on enable loss.
- Used in the control path where decoded strobes must be glitch-free and held for a fixed number of clocks.

Parameters:
- SEL_W, 2, select width per channel; 2^SEL_W outputs per channel; legal range 1..4.
- CHANNELS, 2, number of independent decoder channels; legal range 1..8.
- PULSE_LEN, 1, strobe length in clocks; legal range 1..255.
- CNT_W, derived as $clog2(PULSE_LEN+1); width of the per-channel pulse counter; not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  CHANNELS  per-channel strobe request, sampled on clk.
- sel  input  CHANNELS*SEL_W  per-channel select; channel c uses bits [c*SEL_W +: SEL_W].
- g_n  input  CHANNELS  per-channel active-low enable (G).
- y_n  output  CHANNELS*2^SEL_W  active-low strobes; channel c uses bits [c*2^SEL_W +: 2^SEL_W].
- busy  output  CHANNELS  channel is pulsing (or guarding); new requests are ignored.
- done  output  CHANNELS  one-clock pulse when a strobe completes normally.

Behaviour:
- Reset (reset_n=0, asynchronous): all y_n=1, busy=0, done=0, counters=0, every FSM in IDLE. Takes effect immediately, including mid-pulse. The first accept is possible on the first edge after reset_n rises.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Per-channel FSM, channels fully independent:
  - IDLE -> PULSE on an edge with req=1 and g_n=0. At that edge: latch sel into sel_q, load cnt=PULSE_LEN-1, set busy=1, drive y_n[sel_q]=0.
  - IDLE with req=1 and g_n=1: no action.
  - PULSE, cnt>0, g_n=0: cnt decrements; the strobe is held.
  - PULSE, cnt==0, g_n=0: next edge raises the strobe and pulses done=1 for one clock. Go to IDLE (or GUARD, see Optional Feature). busy=0 in IDLE.
  - PULSE with g_n=1 sampled at an edge: abort. Next edge sets all y_n=1, busy=0, state IDLE, and done stays 0.
- The strobe is low for exactly PULSE_LEN clocks, counted from the accepting edge.
- At most one y_n bit per channel is low at any time. All others are held high.
- sel and req changes during PULSE are ignored; sel_q is stable for the whole pulse.
- req held high continuously re-triggers: the edge that ends a pulse (done=1) cannot accept. The earliest re-accept is the following edge, giving back-to-back strobes separated by one high clock.
- Simultaneous requests on different channels are all accepted in the same cycle.

Optional Feature:
- Macro STROBE_DEC_GUARD_EN.
- Defined: adds a GUARD state after a normal PULSE completion. GUARD lasts 2 clocks with all y_n=1 and busy=1. It returns to IDLE without accepting, giving a minimum 3-clock inter-strobe gap. An abort still goes directly to IDLE.
- Undefined: no GUARD state; the minimum gap is 1 clock.

Decomposition:
- Package strobe_dec_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_PULSE=2'd1, ST_GUARD=2'd2;
  - GUARD_LEN=2;
  - a function computing CNT_W.
- One sub-module, strobe_dec_chan: a single channel FSM, counter and SEL_W-to-2^SEL_W registered one-hot-low decode. The top generates CHANNELS instances and concatenates the outputs.

Test Plan:
- Reset: assert reset_n=0 mid-pulse (CHANNELS=2, PULSE_LEN=3) -> y_n=8'hFF, busy=2'b00 immediately with no clock; a request is accepted on the first edge after release.
- Basic decode: SEL_W=2, PULSE_LEN=3, ch0 req=1 with sel=2'd2 and g_n=0 for one clock -> y_n[3:0]=4'b1011 for exactly 3 clocks, then 4'b1111 with done[0]=1 for one clock; busy[0]=1 for 3 clocks.
- Abort: PULSE_LEN=5, g_n[1] raised in pulse cycle 2 -> ch1 outputs all high the next clock, busy[1]=0, done[1] never asserts.
- Ignore while busy: during ch0 PULSE, change sel to 2'd0 and pulse req -> y_n[2] stays the only low bit, and there is no extra pulse.
- Back-to-back and parallel:
  - req held high on both channels, sel0=1, sel1=3, PULSE_LEN=2 -> both channels pulse simultaneously, repeating every 3 clocks (every 5 with STROBE_DEC_GUARD_EN).
  - One-hot-low check: assert that each channel never has more than one low bit.
